// File: rtl/hazard_pkg.sv
// Shared opcode constants and the per-instruction class used by the hazard scoreboard.
package hazard_pkg;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef struct packed {
      logic use_rs1;
      logic use_rs2;
      logic writes_rd;
      logic is_load;
      logic is_ctrl;
   } instr_class_t;

endpackage

// File: rtl/hazard_instr_decode.sv
// Classifies an instruction by opcode: which source fields it reads, whether it
// writes rd, and whether it is a load or a control-transfer instruction.
module hazard_instr_decode
   import hazard_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_t cls
);

   // Only the opcode matters here; the rest of the word is decoded elsewhere.
   logic unused_fields;
   assign unused_fields = ^instr[31:7];

   // Opcode to class table; unknown opcodes read nothing and write nothing.
   always_comb begin
      cls = '0;
      case (instr[6:0])
         LUI, AUIPC, JAL: begin
            cls.writes_rd = 1'b1;
            cls.is_ctrl   = (instr[6:0] == JAL);
         end
         JALR: begin
            cls.use_rs1   = 1'b1;
            cls.writes_rd = 1'b1;
            cls.is_ctrl   = 1'b1;
         end
         LOAD: begin
            cls.use_rs1   = 1'b1;
            cls.writes_rd = 1'b1;
            cls.is_load   = 1'b1;
         end
         OP_IMM: begin
            cls.use_rs1   = 1'b1;
            cls.writes_rd = 1'b1;
         end
         OP: begin
            cls.use_rs1   = 1'b1;
            cls.use_rs2   = 1'b1;
            cls.writes_rd = 1'b1;
         end
         BRANCH: begin
            cls.use_rs1 = 1'b1;
            cls.use_rs2 = 1'b1;
            cls.is_ctrl = 1'b1;
         end
         STORE: begin
            cls.use_rs1 = 1'b1;
            cls.use_rs2 = 1'b1;
         end
         default: cls = '0;
      endcase
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard hazard unit for the 5-stage pipeline. Drives the
// pipeline-register enables/flushes and the PC enable, and counts stall cycles.
// Build option: HAZARD_FORWARD_EN (bypass network present, only loads are scored).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned SB_DEPTH = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_taken,
   input  logic             ex_busy,
   input  logic [31:0]      instr_D,
   input  logic [31:0]      instr_E,
   output logic             pc_enable,
   output logic             IF_ID_enable,
   output logic             ID_EX_enable,
   output logic             EX_ME_enable,
   output logic             ME_WB_enable,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             EX_ME_flush,
   output logic             ME_WB_flush,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned CW = $clog2(SB_DEPTH + 1);
   localparam int unsigned AW = $clog2(NREG);

   instr_class_t id_cls;
   instr_class_t ex_cls;

   hazard_instr_decode u_decode_id (
      .instr (instr_D),
      .cls   (id_cls)
   );

   hazard_instr_decode u_decode_ex (
      .instr (instr_E),
      .cls   (ex_cls)
   );

   logic [AW-1:0]    rs1;
   logic [AW-1:0]    rs2;
   logic [AW-1:0]    rd;
   logic [CW-1:0]    cnt_q [NREG];
   logic [CW-1:0]    cnt_d [NREG];
   logic [CW-1:0]    score_val;
   logic [CNT_W-1:0] stall_q;
   logic             raw;
   logic             redirect;
   logic             issue;
   logic             stall_event;

   assign rs1 = instr_D[15 +: AW];
   assign rs2 = instr_D[20 +: AW];
   assign rd  = instr_D[7 +: AW];

   // x0 never holds a nonzero count, so reads of x0 are never hazards.
   assign raw = (id_cls.use_rs1 && (cnt_q[rs1] != '0)) ||
                (id_cls.use_rs2 && (cnt_q[rs2] != '0));

   assign redirect    = is_taken && ex_cls.is_ctrl;
   assign issue       = !rst && !ex_busy && !redirect && !raw;
   // A freeze counts even if a redirect is waiting; a redirect cancels the RAW stall.
   assign stall_event = ex_busy || (raw && !redirect);

   // Cycles until the issuing instruction's result is visible in ID.
   always_comb begin
`ifdef HAZARD_FORWARD_EN
      score_val = id_cls.is_load ? CW'(1) : '0;
`else
      score_val = id_cls.writes_rd ? CW'(SB_DEPTH) : '0;
`endif
   end

   // Next counter values: issue load beats decrement, everything holds while frozen.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!ex_busy && (r != 0)) begin
            if (issue && (score_val != '0) && (rd == AW'(r))) begin
               cnt_d[r] = score_val;
            end else if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - 1'b1;
            end
         end
      end
   end

   // Scoreboard counters.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (rst) begin
            cnt_q[r] <= '0;
         end else begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Saturating count of stalled or frozen ID cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (stall_event && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_count = stall_q;

   // Pipeline control by priority: reset, freeze, redirect, RAW stall, run.
   always_comb begin
      pc_enable    = 1'b1;
      IF_ID_enable = 1'b1;
      ID_EX_enable = 1'b1;
      EX_ME_enable = 1'b1;
      ME_WB_enable = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_ME_flush  = 1'b0;
      ME_WB_flush  = 1'b0;
      if (rst) begin
         pc_enable   = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         EX_ME_flush = 1'b1;
         ME_WB_flush = 1'b1;
      end else if (ex_busy) begin
         // Hold the front end and feed bubbles past EX; a pending redirect waits.
         pc_enable    = 1'b0;
         IF_ID_enable = 1'b0;
         ID_EX_enable = 1'b0;
         EX_ME_flush  = 1'b1;
      end else if (redirect) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (raw) begin
         pc_enable    = 1'b0;
         IF_ID_enable = 1'b0;
         ID_EX_flush  = 1'b1;
      end
   end

   // Class bits that this configuration does not consume.
   logic unused_cls;
   assign unused_cls = ^{ex_cls.use_rs1, ex_cls.use_rs2, ex_cls.writes_rd, ex_cls.is_load,
                         id_cls.is_ctrl, id_cls.is_load, id_cls.writes_rd};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by random
// traffic, all compared against a ready-time model of register availability.
module tb_hazard_scoreboard;

   localparam int unsigned NREG     = 32;
   localparam int unsigned SB_DEPTH = 2;
   localparam int unsigned CNT_W    = 6;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BOGUS  = 7'b1111111;

`ifdef HAZARD_FORWARD_EN
   localparam int ALU_STALL  = 0;
   localparam int LOAD_STALL = 1;
`else
   localparam int ALU_STALL  = SB_DEPTH;
   localparam int LOAD_STALL = SB_DEPTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             is_taken = 1'b0;
   logic             ex_busy = 1'b0;
   logic [31:0]      instr_D = 32'h0000_0013;
   logic [31:0]      instr_E = 32'h0000_0013;
   logic             pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable;
   logic             IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush;
   logic [CNT_W-1:0] stall_count;

   hazard_scoreboard #(
      .NREG     (NREG),
      .SB_DEPTH (SB_DEPTH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .is_taken     (is_taken),
      .ex_busy      (ex_busy),
      .instr_D      (instr_D),
      .instr_E      (instr_E),
      .pc_enable    (pc_enable),
      .IF_ID_enable (IF_ID_enable),
      .ID_EX_enable (ID_EX_enable),
      .EX_ME_enable (EX_ME_enable),
      .ME_WB_enable (ME_WB_enable),
      .IF_ID_flush  (IF_ID_flush),
      .ID_EX_flush  (ID_EX_flush),
      .EX_ME_flush  (EX_ME_flush),
      .ME_WB_flush  (ME_WB_flush),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: adv counts non-frozen cycles; a register is readable once adv >= ready_at.
   int ready_at [32];
   int adv      = 0;
   int m_stalls = 0;
   logic obs_pc;

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int s1,
                                       input int s2);
      return {7'b0, 5'(s2), 5'(s1), 3'b0, 5'(rd), op};
   endfunction

   function automatic bit uses1(input logic [6:0] op);
      return op inside {OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_BRANCH, OPC_STORE, OPC_OP};
   endfunction

   function automatic bit uses2(input logic [6:0] op);
      return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
   endfunction

   function automatic int score(input logic [6:0] op);
`ifdef HAZARD_FORWARD_EN
      return (op == OPC_LOAD) ? 1 : 0;
`else
      return (op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP})
             ? int'(SB_DEPTH) : 0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input logic r, input logic [31:0] id, input logic [31:0] ie,
                       input logic tk, input logic bz);
      logic       raw_m, redir_m;
      logic [8:0] exp_v, obs_v;
      int         s1, s2, rd_i, sc;
      @(negedge clk);
      rst = r; instr_D = id; instr_E = ie; is_taken = tk; ex_busy = bz;
      #1;
      s1      = int'(id[19:15]);
      s2      = int'(id[24:20]);
      rd_i    = int'(id[11:7]);
      sc      = score(id[6:0]);
      raw_m   = (uses1(id[6:0]) && s1 != 0 && adv < ready_at[s1]) ||
                (uses2(id[6:0]) && s2 != 0 && adv < ready_at[s2]);
      redir_m = tk && (ie[6:0] inside {OPC_BRANCH, OPC_JAL, OPC_JALR});
      // {pc, IF_ID_en, ID_EX_en, EX_ME_en, ME_WB_en, IF_ID_fl, ID_EX_fl, EX_ME_fl, ME_WB_fl}
      if (r)            exp_v = 9'b0_1111_1111;
      else if (bz)      exp_v = 9'b0_0011_0010;
      else if (redir_m) exp_v = 9'b1_1111_1100;
      else if (raw_m)   exp_v = 9'b0_0111_0100;
      else              exp_v = 9'b1_1111_0000;
      obs_v = {pc_enable, IF_ID_enable, ID_EX_enable, EX_ME_enable, ME_WB_enable,
               IF_ID_flush, ID_EX_flush, EX_ME_flush, ME_WB_flush};
      obs_pc = pc_enable;
      check("ctrl", 32'(obs_v), 32'(exp_v));
      check("stall_count", 32'(stall_count), 32'(m_stalls));
      @(posedge clk);
      if (r) begin
         adv = 0;
         m_stalls = 0;
         for (int i = 0; i < 32; i++) ready_at[i] = 0;
      end else begin
         if ((bz || (raw_m && !redir_m)) && m_stalls < CNT_MAX) m_stalls++;
         if (!bz) begin
            if (!redir_m && !raw_m && rd_i != 0 && sc > 0) ready_at[rd_i] = adv + 1 + sc;
            adv++;
         end
      end
   endtask

   // Hold a dependent instruction in ID until it issues; report stall cycles seen.
   task automatic run_dep(input logic [31:0] id, input int max_cyc, output int nstall);
      nstall = 0;
      for (int i = 0; i < max_cyc; i++) begin
         step(1'b0, id, enc(OPC_OP_IMM, 0, 0, 0), 1'b0, 1'b0);
         if (obs_pc) break;
         nstall++;
      end
   endtask

   initial begin
      logic [31:0] nop;
      logic [6:0]  ops [10];
      int          n;
      nop = enc(OPC_OP_IMM, 0, 0, 0);
      ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
              OPC_LUI, OPC_AUIPC, OPC_BOGUS};
      for (int i = 0; i < 32; i++) ready_at[i] = 0;

      // Reset
      step(1'b1, nop, nop, 1'b0, 1'b0);
      step(1'b1, enc(OPC_OP, 6, 5, 5), nop, 1'b1, 1'b1);
      #1 check("reset_stall_count", 32'(stall_count), 32'd0);

      // ALU RAW: addi x5 ; add x6,x5,x5
      step(1'b0, enc(OPC_OP_IMM, 5, 0, 0), nop, 1'b0, 1'b0);
      run_dep(enc(OPC_OP, 6, 5, 5), 8, n);
      check("alu_raw_stalls", 32'(n), 32'(ALU_STALL));
      #1 check("alu_raw_count", 32'(stall_count), 32'(ALU_STALL));

      // Load-use then ALU pair
      step(1'b1, nop, nop, 1'b0, 1'b0);
      step(1'b0, enc(OPC_LOAD, 7, 1, 0), nop, 1'b0, 1'b0);
      run_dep(enc(OPC_OP, 8, 7, 0), 8, n);
      check("load_use_stalls", 32'(n), 32'(LOAD_STALL));
      step(1'b0, enc(OPC_OP_IMM, 9, 0, 0), nop, 1'b0, 1'b0);
      run_dep(enc(OPC_OP, 10, 9, 9), 8, n);
      check("alu_pair_stalls", 32'(n), 32'(ALU_STALL));

      // JAL reads no sources even when its immediate bits alias x5
      step(1'b0, enc(OPC_LUI, 5, 0, 0), nop, 1'b0, 1'b0);
      step(1'b0, enc(OPC_JAL, 1, 5, 5), enc(OPC_LUI, 5, 0, 0), 1'b0, 1'b0);
      check("jal_no_src", 32'(obs_pc), 32'd1);

      // Freeze with x3 pending, then the stall resumes in full
      step(1'b0, enc(OPC_OP_IMM, 3, 0, 0), nop, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, enc(OPC_OP, 4, 3, 3), nop, 1'b0, 1'b1);
         check("freeze_ex_me_flush", 32'(EX_ME_flush), 32'd1);
      end
      run_dep(enc(OPC_OP, 4, 3, 3), 8, n);
      check("post_freeze_stalls", 32'(n), 32'(ALU_STALL));

      // Reset mid-stall clears pending state and the counter
      step(1'b0, enc(OPC_OP_IMM, 5, 0, 0), nop, 1'b0, 1'b0);
      step(1'b1, enc(OPC_OP, 6, 5, 5), nop, 1'b0, 1'b0);
      #1 check("reset_clears_count", 32'(stall_count), 32'd0);
      run_dep(enc(OPC_OP, 6, 5, 5), 8, n);
      check("post_reset_stalls", 32'(n), 32'd0);

      // Taken branch kills a RAW-stalled add; its rd never gets scored
      step(1'b0, enc(OPC_OP_IMM, 5, 0, 0), nop, 1'b0, 1'b0);
      step(1'b0, enc(OPC_OP, 6, 5, 5), enc(OPC_BRANCH, 0, 1, 2), 1'b1, 1'b0);
      check("redirect_pc", 32'(obs_pc), 32'd1);
      check("redirect_if_id_flush", 32'(IF_ID_flush), 32'd1);
      #1 check("redirect_no_stall", 32'(stall_count), 32'd0);
      step(1'b0, nop, nop, 1'b0, 1'b0);
      run_dep(enc(OPC_OP, 11, 6, 6), 8, n);
      check("killed_rd_unscored", 32'(n), 32'd0);

      // Saturation of the stall counter
      for (int i = 0; i < CNT_MAX + 8; i++) step(1'b0, nop, nop, 1'b0, 1'b1);
      #1 check("stall_saturate", 32'(stall_count), 32'(CNT_MAX));
      step(1'b1, nop, nop, 1'b0, 1'b0);

      // Random traffic over a small register window
      for (int i = 0; i < 800; i++) begin
         logic [31:0] rid, rie;
         rid = enc(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7));
         rie = enc(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7));
         step(($urandom_range(0, 39) == 0), rid, rie, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 5) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, sequential hazard unit for the 5-stage RV32I pipeline (IF/ID/EX/ME/WB). It replaces address-compare stalling with a per-register pending-write scoreboard, so stalls depend on which source fields the decoded opcode actually uses. It also adds a multi-cycle EX freeze and a saturating stall counter. It sits beside the pipeline registers and drives their enable/flush pins and the PC enable.

## Interface
- `NREG`, 32: architectural registers; x0 is never scored.
- `SB_DEPTH`, 2: advancing cycles after issue (ID→EX) until a result is readable in ID through the write-through register file.
- `CNT_W`, 32: stall-counter width.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `is_taken` input 1: branch/jump resolved taken in EX.
- `ex_busy` input 1: multi-cycle EX operation still in progress.
- `instr_D`, `instr_E` input 32: instructions in ID and EX. A flushed slot holds a NOP with rd=x0.
- `pc_enable`, `IF_ID_enable`, `ID_EX_enable`, `EX_ME_enable`, `ME_WB_enable` output 1: pipeline-register enables.
- `IF_ID_flush`, `ID_EX_flush`, `EX_ME_flush`, `ME_WB_flush` output 1: pipeline-register flushes.
- `stall_count` output CNT_W: cycles in which ID was stalled or frozen.

## Operation
- Source decode by opcode:
  - LUI, AUIPC, JAL: no sources.
  - JALR, LOAD, OP-IMM: rs1 only.
  - BRANCH, STORE, OP: rs1 and rs2.
  - Writers: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- Scoreboard: one `$clog2(SB_DEPTH+1)`-bit counter per register. `raw` is asserted when a used source of `instr_D` has a nonzero counter.
- Action priority, highest first:
  1. `rst`: `pc_enable=0`, all four flushes = 1, all other enables = 1.
  2. `ex_busy` (freeze): `pc_enable`, `IF_ID_enable`, `ID_EX_enable` = 0; `EX_ME_flush=1`. Any redirect is deferred until `ex_busy` falls.
  3. Redirect (`is_taken` and `instr_E` is BRANCH/JAL/JALR): `IF_ID_flush=1`, `ID_EX_flush=1`, PC enabled.
  4. `raw`: `pc_enable=0`, `IF_ID_enable=0`, `ID_EX_flush=1`.
  5. Otherwise all enables = 1 and all flushes = 0.
- Issue occurs when none of priorities 1–4 applies. On issue, a writer with rd≠0 loads `cnt[rd]` with its issue value.
- Decrement: in every non-frozen cycle, each nonzero counter that is not being loaded decrements by 1. During a freeze all counters hold.
- Simultaneous issue and decrement on the same rd: the load wins. A WAW issue simply reloads the counter.
- `stall_count` increments when priority 2 or 4 is active; it saturates at all-ones.

## Timing
- All control outputs are combinational from the scoreboard state and the inputs. The scoreboard and `stall_count` are registered.
- Reset values: every counter = 0, `stall_count=0`. Outputs follow priority 1 while `rst` is high.
- Back-to-back ALU RAW without forwarding: ID stalls for `SB_DEPTH` cycles, and the dependent instruction issues on cycle `SB_DEPTH+1` after the producer issues.
- A redirect costs 2 bubbles. Because a killed ID instruction never issues, it never marks the scoreboard.
- Reset asserted mid-stall clears all pending state at the next edge. The first post-reset ID instruction is not stalled.

## Configuration
- `HAZARD_FORWARD_EN` defined (EX/ME/WB forwarding present):
  - Only LOAD issues score rd, with value 1.
  - Other writers are not scored.
  - A load-use pair therefore costs exactly 1 stall.
- Undefined: every writer scores rd with value `SB_DEPTH`.

## Structure
- `hazard_pkg` holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - `typedef struct packed {logic use_rs1, use_rs2, writes_rd, is_load, is_ctrl;} instr_class_t`.
- One sub-module, `hazard_instr_decode`, maps a 32-bit instruction to `instr_class_t`. It is instantiated twice, for ID and EX.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5` (no forwarding, `SB_DEPTH`=2) → `pc_enable`=0 for exactly 2 cycles, `ID_EX_flush`=1 in both, dependent issues in the 3rd cycle. `stall_count`=2.
- `lw x7,0(x1)` then `add x8,x7,x0` with `HAZARD_FORWARD_EN` → exactly 1 stall cycle. `addi x9,x0,3` then `add x10,x9,x9` → 0 stalls.
- `lui x5,1` in EX and `jal x1,8` in ID (rd/rs field bits alias x5) → no stall, because JAL uses no sources.
- `ex_busy` high for 4 cycles with `addi x3` pending → PC/IF_ID/ID_EX held and `EX_ME_flush`=1 for all 4 cycles. `cnt[x3]` holds its value, then the stall resumes after `ex_busy` falls.
- `beq` taken in EX while `ex_busy`=0 and ID holds a RAW-stalled `add` → `IF_ID_flush`=`ID_EX_flush`=1, `pc_enable`=1, no stall counted. The `add`'s rd is not scored.
- Assert `rst` for 1 cycle while `cnt[x5]`=2 → all counters and `stall_count` read 0, and the next `add x6,x5,x5` issues without a stall.
